sram_sp_masked_init: RTL and testbench
======================================

// Module: sram_sp_masked_init
// PURPOSE
//  Parametrised single-port, byte-lane-style masked SRAM model; successor to the fixed 256x96 array macros.
//  Adds a hardware init sweep after reset, an optional output pipeline register, held read data and a read-valid strobe.
//  Sits under cache/TLB data and tag arrays; one RW port per instance.
// PARAMETERS
//  ADDR_W    8    address width
//  DEPTH     256  number of words (<= 2**ADDR_W)
//  DATA_W    96   word width
//  MASK_GRAN 24   bits per write-mask lane; DATA_W % MASK_GRAN == 0; MASK_SEG = DATA_W/MASK_GRAN
//  OUT_REG   0    0: read latency 1; 1: extra output register, read latency 2
//  INIT_VAL  0    DATA_W-bit value written to every word by the init sweep
// PORTS
//  RW0_clk    in   1         clock, all state on posedge
//  RW0_reset  in   1         synchronous active-high reset
//  RW0_addr   in   ADDR_W    word address
//  RW0_en     in   1         request valid this cycle
//  RW0_wmode  in   1         1 = write, 0 = read
//  RW0_wmask  in   MASK_SEG  per-lane write enable; bit i covers wdata[i*MASK_GRAN +: MASK_GRAN]
//  RW0_wdata  in   DATA_W    write data
//  RW0_rdata  out  DATA_W    read data; holds value of last completed read
//  RW0_rvalid out  1         one-cycle pulse when RW0_rdata carries a new read result
//  init_busy  out  1         1 while the init sweep runs; requests ignored
// BEHAVIOUR
//  Reset (sampled at posedge): state<=INIT, sweep cnt<=0, init_busy<=1, RW0_rvalid<=0, RW0_rdata<=0, pipeline valids cleared.
//  Array contents are not reset directly; the sweep overwrites them.
//  FSM INIT: each posedge with reset low: mem[cnt]<=INIT_VAL, cnt<=cnt+1; at cnt==DEPTH-1 -> READY, init_busy<=0.
//   - init_busy is high for exactly DEPTH cycles after reset deasserts.
//   - RW0_en in INIT is dropped: no write, no rvalid, no stall/queue.
//  FSM READY: stays until reset. Reset in any state (incl. mid-sweep, mid-read) restarts sweep at 0 and kills in-flight reads.
//  Write (en & wmode, READY): lanes with wmask[i]=1 updated at the posedge; other lanes unchanged. wmask==0 is a no-op.
//   - No rvalid for writes; RW0_rdata unchanged.
//  Read (en & !wmode, READY): word sampled at the request posedge.
//   - OUT_REG=0: rdata/rvalid updated at that same posedge (visible next cycle).
//   - OUT_REG=1: one posedge later.
//   - Reads fully pipelined; back-to-back reads give back-to-back rvalid.
//   - A read following a write to same addr returns the new data.
//  Out of range (addr >= DEPTH): write ignored; read returns all zeros with rvalid pulse.
//  RW0_rdata is held between reads (no garbage/randomisation); rvalid is 0 on cycles without a completing read.
//  Single port: one operation per cycle; wmode selects. No read-during-write case exists.
// TESTING
//  Reset 1 cycle, DEPTH=256: init_busy high 256 cycles then 0; read addr 0x05 -> rdata=0, rvalid 1 cycle later.
//  Write addr 0x10 data 96'hAAAAAA_BBBBBB_CCCCCC_DDDDDD wmask=4'hF, then wmask=4'b0101 data all-1s;
//   read -> 96'hAAAAAA_FFFFFF_CCCCCC_FFFFFF.
//  Write + read request on cycle 10 of the sweep -> no rvalid, word unchanged (reads INIT_VAL after init).
//  OUT_REG=1: reads to 1,2,3 on consecutive cycles -> rvalid high 3 cycles, first 2 cycles after first request, data in order.
//  Reset asserted the cycle after a read request -> no rvalid; init_busy restarts for DEPTH cycles; prior writes gone.
//  DEPTH=200, ADDR_W=8: write addr 220 then read 220 -> rdata=0 with rvalid; addr 199 stays INIT_VAL.

Source files
------------

// File: rtl/sram_sp_masked_init_if.sv
// Request/response bundle for the single RW port of sram_sp_masked_init.
// The master drives requests; the slave (the memory) returns read data, the valid strobe and busy.
interface sram_sp_masked_init_if #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 96,
  parameter int unsigned MASK_GRAN = 24
);
  localparam int unsigned MASK_SEG = DATA_W / MASK_GRAN;

  logic [ADDR_W-1:0]   RW0_addr;
  logic                RW0_en;
  logic                RW0_wmode;
  logic [MASK_SEG-1:0] RW0_wmask;
  logic [DATA_W-1:0]   RW0_wdata;
  logic [DATA_W-1:0]   RW0_rdata;
  logic                RW0_rvalid;
  logic                init_busy;

  modport master (
    output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
    input  RW0_rdata, RW0_rvalid, init_busy
  );

  modport slave (
    input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
    output RW0_rdata, RW0_rvalid, init_busy
  );
endinterface

// File: rtl/sram_sp_masked_init.sv
// Single-port SRAM model with per-lane write mask, post-reset init sweep,
// optional output register, held read data and a one-cycle read-valid strobe.
module sram_sp_masked_init #(
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       DEPTH     = 256,
  parameter int unsigned       DATA_W    = 96,
  parameter int unsigned       MASK_GRAN = 24,
  parameter int unsigned       OUT_REG   = 0,
  parameter logic [DATA_W-1:0] INIT_VAL  = '0
) (
  input logic                  RW0_clk,
  input logic                  RW0_reset,
  sram_sp_masked_init_if.slave bus
);
  localparam int unsigned       MASK_SEG = DATA_W / MASK_GRAN;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {StInit, StReady} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_we;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              ready;
  logic              in_range;
  logic              req_wr;
  logic              req_rd;
  logic [DATA_W-1:0] rd_word;

  logic              fin_valid;
  logic [DATA_W-1:0] fin_data;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge RW0_clk) begin
    if (RW0_reset) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    unique case (state_q)
      StInit: begin
        init_we = ~RW0_reset;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = StReady;
          cnt_d   = '0;
        end
      end
      StReady: begin
      end
    endcase
  end

  assign ready    = (state_q == StReady);
  assign in_range = (32'(bus.RW0_addr) < DEPTH);
  // Requests arriving while the sweep runs or reset is held are dropped outright.
  assign req_wr   = bus.RW0_en & bus.RW0_wmode & ready & ~RW0_reset & in_range;
  assign req_rd   = bus.RW0_en & ~bus.RW0_wmode & ready & ~RW0_reset;
  assign rd_word  = in_range ? mem_q[bus.RW0_addr] : '0;

  always_ff @(posedge RW0_clk) begin
    if (init_we) begin
      mem_q[cnt_q] <= INIT_VAL;
    end else if (req_wr) begin
      for (int unsigned i = 0; i < MASK_SEG; i++) begin
        if (bus.RW0_wmask[i]) begin
          mem_q[bus.RW0_addr][i*MASK_GRAN +: MASK_GRAN] <=
            bus.RW0_wdata[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              pipe_v_q;
    logic [DATA_W-1:0] pipe_d_q;

    always_ff @(posedge RW0_clk) begin
      if (RW0_reset) begin
        pipe_v_q <= 1'b0;
        pipe_d_q <= '0;
      end else begin
        pipe_v_q <= req_rd;
        if (req_rd) begin
          pipe_d_q <= rd_word;
        end
      end
    end

    assign fin_valid = pipe_v_q;
    assign fin_data  = pipe_d_q;
  end else begin : g_no_out_reg
    assign fin_valid = req_rd;
    assign fin_data  = rd_word;
  end

  // Read data is held until the next completing read replaces it.
  always_ff @(posedge RW0_clk) begin
    if (RW0_reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= fin_valid;
      if (fin_valid) begin
        rdata_q <= fin_data;
      end
    end
  end

  assign bus.RW0_rdata  = rdata_q;
  assign bus.RW0_rvalid = rvalid_q;
  assign bus.init_busy  = (state_q == StInit);
endmodule

// File: tb/tb_sram_sp_masked_init.sv
// Bench for sram_sp_masked_init: three instances (256/latency 1, 256/latency 2, 200/latency 2
// with a non-zero init value) share one stimulus stream and are checked against a word-array model.
module tb_sram_sp_masked_init;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 96;
  localparam int unsigned MG = 24;
  localparam int unsigned MS = DW / MG;
  localparam logic [DW-1:0] INIT_C = 96'h123456_789ABC_DEF012_345678;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          wmode = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [MS-1:0] wmask = '0;
  logic [DW-1:0] wdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_sp_masked_init_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_GRAN(MG)) bus_a ();
  sram_sp_masked_init_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_GRAN(MG)) bus_b ();
  sram_sp_masked_init_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_GRAN(MG)) bus_c ();

  assign bus_a.RW0_addr  = addr;
  assign bus_a.RW0_en    = en;
  assign bus_a.RW0_wmode = wmode;
  assign bus_a.RW0_wmask = wmask;
  assign bus_a.RW0_wdata = wdata;
  assign bus_b.RW0_addr  = addr;
  assign bus_b.RW0_en    = en;
  assign bus_b.RW0_wmode = wmode;
  assign bus_b.RW0_wmask = wmask;
  assign bus_b.RW0_wdata = wdata;
  assign bus_c.RW0_addr  = addr;
  assign bus_c.RW0_en    = en;
  assign bus_c.RW0_wmode = wmode;
  assign bus_c.RW0_wmask = wmask;
  assign bus_c.RW0_wdata = wdata;

  sram_sp_masked_init #(
    .ADDR_W(AW), .DEPTH(256), .DATA_W(DW), .MASK_GRAN(MG), .OUT_REG(0), .INIT_VAL({DW{1'b0}})
  ) dut_a (.RW0_clk(clk), .RW0_reset(rst), .bus(bus_a.slave));

  sram_sp_masked_init #(
    .ADDR_W(AW), .DEPTH(256), .DATA_W(DW), .MASK_GRAN(MG), .OUT_REG(1), .INIT_VAL({DW{1'b0}})
  ) dut_b (.RW0_clk(clk), .RW0_reset(rst), .bus(bus_b.slave));

  sram_sp_masked_init #(
    .ADDR_W(AW), .DEPTH(200), .DATA_W(DW), .MASK_GRAN(MG), .OUT_REG(1), .INIT_VAL(INIT_C)
  ) dut_c (.RW0_clk(clk), .RW0_reset(rst), .bus(bus_c.slave));

  // Reference model: word arrays, a countdown of blocked cycles, and the read results in flight.
  logic [DW-1:0] mem_m [3][256];
  int            busy_m [3];
  logic          rv_m [3];
  logic [DW-1:0] rd_m [3];
  logic          pv_m [3];
  logic [DW-1:0] pd_m [3];

  function automatic int dep(input int d);
    return (d == 2) ? 200 : 256;
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic logic [DW-1:0] initv(input int d);
    return (d == 2) ? INIT_C : '0;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      logic          hit;
      logic [DW-1:0] w;
      hit = 1'b0;
      w   = '0;
      if (rst) begin
        busy_m[d] = dep(d);
        for (int i = 0; i < 256; i++) mem_m[d][i] = initv(d);
        rv_m[d] = 1'b0;
        rd_m[d] = '0;
        pv_m[d] = 1'b0;
        pd_m[d] = '0;
      end else begin
        if (busy_m[d] > 0) begin
          busy_m[d]--;
        end else if (en && wmode) begin
          if (int'(addr) < dep(d)) begin
            for (int l = 0; l < MS; l++) begin
              if (wmask[l]) mem_m[d][addr][l*MG +: MG] = wdata[l*MG +: MG];
            end
          end
        end else if (en) begin
          hit = 1'b1;
          w   = (int'(addr) < dep(d)) ? mem_m[d][addr] : '0;
        end
        if (lat(d) == 1) begin
          rv_m[d] = hit;
          if (hit) rd_m[d] = w;
        end else begin
          rv_m[d] = pv_m[d];
          if (pv_m[d]) rd_m[d] = pd_m[d];
          pv_m[d] = hit;
          pd_m[d] = w;
        end
      end
    end
  endtask

  task automatic chk_dut(input string nm, input int d, input logic busy, input logic rv,
                         input logic [DW-1:0] rdata);
    chk({nm, "_init_busy"}, DW'(busy), DW'(busy_m[d] > 0));
    chk({nm, "_rvalid"}, DW'(rv), DW'(rv_m[d]));
    chk({nm, "_rdata"}, rdata, rd_m[d]);
  endtask

  // One clock: model follows the posedge, outputs are sampled 1ns later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk_dut("a", 0, bus_a.init_busy, bus_a.RW0_rvalid, bus_a.RW0_rdata);
    chk_dut("b", 1, bus_b.init_busy, bus_b.RW0_rvalid, bus_b.RW0_rdata);
    chk_dut("c", 2, bus_c.init_busy, bus_c.RW0_rvalid, bus_c.RW0_rdata);
  endtask

  task automatic run_sweep(input bit poke, output int na, output int nc, output int nrv);
    na  = bus_a.init_busy ? 1 : 0;
    nc  = bus_c.init_busy ? 1 : 0;
    nrv = 0;
    for (int k = 0; k < 300; k++) begin
      en    = poke && (k == 10 || k == 11);
      wmode = (k == 10);
      addr  = 8'h07;
      wmask = '1;
      wdata = '1;
      cyc();
      if (bus_a.init_busy) na++;
      if (bus_c.init_busy) nc++;
      nrv += int'(bus_a.RW0_rvalid) + int'(bus_b.RW0_rvalid) + int'(bus_c.RW0_rvalid);
    end
    en = 1'b0;
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [MS-1:0] m;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int            na, nc, nrv, seen;
    logic [DW-1:0] d1, d2, d3;

    tbl[0] = '{1'b1, 8'h10, 4'hF, 96'hAAAAAA_BBBBBB_CCCCCC_DDDDDD, '0};
    tbl[1] = '{1'b1, 8'h10, 4'b0101, {DW{1'b1}}, '0};
    tbl[2] = '{1'b0, 8'h10, 4'h0, '0, 96'hAAAAAA_FFFFFF_CCCCCC_FFFFFF};
    tbl[3] = '{1'b0, 8'h05, 4'h0, '0, '0};
    tbl[4] = '{1'b0, 8'h07, 4'h0, '0, '0};
    tbl[5] = '{1'b1, 8'h20, 4'h0, {DW{1'b1}}, '0};
    tbl[6] = '{1'b0, 8'h20, 4'h0, '0, '0};
    tbl[7] = '{1'b1, 8'hFF, 4'b1000, 96'h111111_222222_333333_444444, '0};
    tbl[8] = '{1'b0, 8'hFF, 4'h0, '0, 96'h111111_000000_000000_000000};

    // Reset state and init sweep length, with a write+read poked mid-sweep.
    rst = 1'b1;
    cyc();
    chk("reset_busy_a", DW'(bus_a.init_busy), DW'(1'b1));
    chk("reset_rvalid_b", DW'(bus_b.RW0_rvalid), DW'(1'b0));
    chk("reset_rdata_a", bus_a.RW0_rdata, '0);
    rst = 1'b0;
    run_sweep(1'b1, na, nc, nrv);
    chk_int("init_len_a", na, 256);
    chk_int("init_len_c", nc, 200);
    chk_int("sweep_rvalids", nrv, 0);

    // Table-driven writes/reads on the latency-1 instance.
    for (int i = 0; i < 9; i++) begin
      en    = 1'b1;
      wmode = tbl[i].we;
      addr  = tbl[i].a;
      wmask = tbl[i].m;
      wdata = tbl[i].wd;
      cyc();
      chk($sformatf("tbl%0d_rvalid", i), DW'(bus_a.RW0_rvalid), DW'(!tbl[i].we));
      if (!tbl[i].we) chk($sformatf("tbl%0d_rdata", i), bus_a.RW0_rdata, tbl[i].exp);
    end
    en = 1'b0;
    cyc();

    // Back-to-back reads through the output register.
    d1 = 96'h0A0A0A_010101_FEDCBA_000001;
    d2 = 96'h0B0B0B_020202_987654_000002;
    d3 = 96'h0C0C0C_030303_321000_000003;
    en = 1'b1; wmode = 1'b1; wmask = '1;
    addr = 8'd1; wdata = d1; cyc();
    addr = 8'd2; wdata = d2; cyc();
    addr = 8'd3; wdata = d3; cyc();
    wmode = 1'b0;
    addr = 8'd1; cyc();
    chk("b2b_v0", DW'(bus_b.RW0_rvalid), DW'(1'b0));
    addr = 8'd2; cyc();
    chk("b2b_v1", DW'(bus_b.RW0_rvalid), DW'(1'b1));
    chk("b2b_d1", bus_b.RW0_rdata, d1);
    addr = 8'd3; cyc();
    chk("b2b_v2", DW'(bus_b.RW0_rvalid), DW'(1'b1));
    chk("b2b_d2", bus_b.RW0_rdata, d2);
    en = 1'b0; cyc();
    chk("b2b_v3", DW'(bus_b.RW0_rvalid), DW'(1'b1));
    chk("b2b_d3", bus_b.RW0_rdata, d3);
    cyc();
    chk("b2b_v4", DW'(bus_b.RW0_rvalid), DW'(1'b0));
    chk("b2b_hold", bus_b.RW0_rdata, d3);

    // Out-of-range write and read on the 200-word instance.
    en = 1'b1; wmode = 1'b1; wmask = '1; wdata = '1; addr = 8'd220; cyc();
    wmode = 1'b0; cyc();
    chk("oor_v0", DW'(bus_c.RW0_rvalid), DW'(1'b0));
    addr = 8'd199; cyc();
    chk("oor_v1", DW'(bus_c.RW0_rvalid), DW'(1'b1));
    chk("oor_d220", bus_c.RW0_rdata, '0);
    en = 1'b0; cyc();
    chk("oor_v2", DW'(bus_c.RW0_rvalid), DW'(1'b1));
    chk("oor_d199", bus_c.RW0_rdata, INIT_C);
    cyc();
    chk("oor_v3", DW'(bus_c.RW0_rvalid), DW'(1'b0));

    // Reset right after a read request kills it and wipes earlier writes.
    en = 1'b1; wmode = 1'b0; addr = 8'h10; cyc();
    seen = int'(bus_b.RW0_rvalid);
    en = 1'b0; rst = 1'b1; cyc();
    seen += int'(bus_b.RW0_rvalid);
    rst = 1'b0;
    run_sweep(1'b0, na, nc, nrv);
    chk_int("killed_read_b", seen + nrv, 0);
    chk_int("reinit_len_a", na, 256);
    chk_int("reinit_len_c", nc, 200);
    en = 1'b1; wmode = 1'b0; addr = 8'h10; cyc();
    chk("wiped_v_a", DW'(bus_a.RW0_rvalid), DW'(1'b1));
    chk("wiped_d_a", bus_a.RW0_rdata, '0);
    en = 1'b0; cyc();
    chk("wiped_v_b", DW'(bus_b.RW0_rvalid), DW'(1'b1));
    chk("wiped_d_b", bus_b.RW0_rdata, '0);

    // Random traffic with occasional resets, checked every cycle by the model.
    for (int k = 0; k < 2000; k++) begin
      int unsigned sel;
      rst   = ($urandom_range(0, 499) == 0);
      en    = ($urandom_range(0, 3) != 0);
      wmode = $urandom_range(0, 1) != 0;
      sel   = $urandom_range(0, 3);
      case (sel)
        0:       addr = 8'($urandom_range(0, 15));
        1:       addr = 8'($urandom_range(190, 230));
        2:       addr = 8'($urandom);
        default: addr = 8'($urandom_range(16, 19));
      endcase
      wmask = 4'($urandom);
      wdata = {$urandom, $urandom, $urandom};
      cyc();
    end
    rst = 1'b0;
    en  = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
